spi_slave_gen: RTL and testbench

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

---
 rtl/spi_slave_gen.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen.sv
// SPI slave with a one-word transmit buffer and one-word receive register.
// sck, ssn and mosi are asynchronous and are resynchronised into clk before use.
// Clock polarity and phase are selectable at run time through cfg_cpol/cfg_cpha.
// Several words can be exchanged back to back within one ssn-low frame.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_cpol, cfg_cpha  SCK idle level; sample on leading (0) or trailing (1) edge
//   tx_data/valid/ready transmit buffer write handshake
//   tx_underrun         sticky: a word was sent while the buffer was empty
//   rx_data/valid/ready received word handshake
//   rx_overrun          sticky: a received word was dropped
//   clr_flags           clears both sticky flags
//   busy                frame in progress
//   sck, ssn, mosi      SPI inputs (asynchronous)
//   miso                SPI output, registered
//
// state  | meaning
// IDLE   | ssn high, SPI edges ignored, miso held at 0
// ACTIVE | ssn low, shifting words
module spi_slave_gen #(
    parameter int DATA_W      = 8,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic              clr_flags,
    output logic              busy,
    input  logic              sck,
    input  logic              ssn,
    input  logic              mosi,
    output logic              miso
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, ssn_sync, mosi_sync;
    logic sck_s, ssn_s, mosi_s, sck_d, ssn_d;
    logic sck_edge, lead_edge, trail_edge, ssn_fall, ssn_rise;
    logic run, start, sample_evt, shift_evt, last_sample, load, shift_only, tx_bit;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, rx_word;
    logic [DATA_W-1:0] tx_shift, tx_shifted;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic              reload_pend, skip_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ssn_sync  <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ssn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            ssn_d     <= ssn_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ssn_s  = ssn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_edge   = sck_s ^ sck_d;
    assign lead_edge  = sck_edge & (sck_s ^ cfg_cpol);
    assign trail_edge = sck_edge & ~(sck_s ^ cfg_cpol);
    assign ssn_fall   = ssn_d & ~ssn_s;
    assign ssn_rise   = ~ssn_d & ssn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ssn_fall) state_next = ACTIVE;
            ACTIVE:  if (ssn_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An edge seen in the same clk as ssn rising belongs to an aborted frame.
    assign run         = (state == ACTIVE) && !ssn_rise;
    assign start       = (state == IDLE) && ssn_fall;
    assign sample_evt  = run && (cfg_cpha ? trail_edge : lead_edge);
    assign shift_evt   = run && (cfg_cpha ? lead_edge : trail_edge);
    assign last_sample = sample_evt && (bit_cnt == CNT_LAST);
    // With cpha=1 the first bit is already on miso before the first leading edge.
    assign load        = start || (shift_evt && reload_pend);
    assign shift_only  = shift_evt && !reload_pend && !skip_first;

    assign rx_word    = LSB_FIRST ? {mosi_s, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], mosi_s};
    assign tx_shifted = LSB_FIRST ? {1'b0, tx_shift[DATA_W-1:1]} : {tx_shift[DATA_W-2:0], 1'b0};
    assign tx_bit     = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            reload_pend <= 1'b0;
            skip_first  <= 1'b0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            miso        <= 1'b0;
        end else begin
            if (start) begin
                bit_cnt     <= '0;
                rx_shift    <= '0;
                reload_pend <= 1'b0;
                skip_first  <= cfg_cpha;
            end else begin
                if (sample_evt) begin
                    rx_shift <= rx_word;
                    bit_cnt  <= last_sample ? '0 : bit_cnt + CNT_W'(1);
                    if (last_sample) reload_pend <= 1'b1;
                end
                if (shift_evt) begin
                    skip_first  <= 1'b0;
                    reload_pend <= 1'b0;
                end
            end

            // A load in the same clk as a write takes the old buffer contents.
            if (load)            tx_shift <= buf_full ? buf_data : '0;
            else if (shift_only) tx_shift <= tx_shifted;

            if (tx_valid && !buf_full) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (clr_flags)              tx_underrun <= 1'b0;
            else if (load && !buf_full) tx_underrun <= 1'b1;

            if (last_sample) begin
                if (!(rx_valid && !rx_ready)) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (clr_flags)                                 rx_overrun <= 1'b0;
            else if (last_sample && rx_valid && !rx_ready) rx_overrun <= 1'b1;

            miso <= (state == ACTIVE) ? tx_bit : 1'b0;
        end
    end

    assign tx_ready = ~buf_full;
    assign busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: an MSB-first and an LSB-first instance share one
// SPI bus and one buffer interface. A frame-level model predicts transmitted
// and received words into queues; independent monitors pop and compare.
module tb_spi_slave_gen;
    localparam int H = 6;  // SCK half period and guard times, in clk

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0, rx_ready = 1'b1, clr_flags = 1'b0;
    logic sck = 1'b0, ssn = 1'b1, mosi = 1'b0;

    logic tx_ready_m, tx_underrun_m, rx_valid_m, rx_overrun_m, busy_m, miso_m;
    logic tx_ready_l, tx_underrun_l, rx_valid_l, rx_overrun_l, busy_l, miso_l;
    logic [7:0] rx_data_m, rx_data_l;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq_m[$];
    logic [7:0] rxq_l[$];

    bit         mdl_full = 1'b0;
    logic [7:0] mdl_buf = 8'h00;
    bit         mdl_unr = 1'b0, mdl_ovr = 1'b0, mdl_pend = 1'b0, hold = 1'b0;
    logic [7:0] mdl_last_m = 8'h00, mdl_last_l = 8'h00;

    spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_m),
        .tx_underrun(tx_underrun_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m),
        .rx_ready(rx_ready), .rx_overrun(rx_overrun_m), .clr_flags(clr_flags),
        .busy(busy_m), .sck(sck), .ssn(ssn), .mosi(mosi), .miso(miso_m));

    spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_l),
        .tx_underrun(tx_underrun_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
        .rx_ready(rx_ready), .rx_overrun(rx_overrun_l), .clr_flags(clr_flags),
        .busy(busy_l), .sck(sck), .ssn(ssn), .mosi(mosi), .miso(miso_l));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] msbw(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[j]      = a[7-j];
            r[8+j]    = b[7-j];
            r[16+j]   = c[7-j];
        end
        return r;
    endfunction

    // Word that goes onto the wire when the slave loads from its buffer.
    task automatic mdl_load(output logic [7:0] w);
        if (mdl_full) begin
            w = mdl_buf;
            mdl_full = 1'b0;
        end else begin
            w = 8'h00;
            mdl_unr = 1'b1;
        end
    endtask

    task automatic mdl_rx(input logic [7:0] wm, input logic [7:0] wl);
        if (!hold || !mdl_pend) begin
            rxq_m.push_back(wm);
            rxq_l.push_back(wl);
            mdl_last_m = wm;
            mdl_last_l = wl;
            if (hold) mdl_pend = 1'b1;
        end else begin
            mdl_ovr = 1'b1;
        end
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        @(negedge clk);
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        sck = cpol;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] v);
        @(negedge clk);
        chk("tx_ready_before_write", 32'(tx_ready_m), 32'(!mdl_full));
        tx_data = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        mdl_buf = v;
        mdl_full = 1'b1;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        mdl_unr = 1'b0;
        mdl_ovr = 1'b0;
        chk("underrun_cleared", 32'(tx_underrun_m), 32'd0);
        chk("overrun_cleared", 32'(rx_overrun_m), 32'd0);
    endtask

    // wmode 0: no write; 1: write in the same clk as the frame-start load;
    // 2: write shortly after the frame-start load.
    task automatic run_frame(input int nbits, input logic [63:0] bits, input int wmode, input logic [7:0] wval);
        logic [7:0] tw, rm, rl;
        bit full_before;
        int nw;
        nw = nbits / 8;
        full_before = mdl_full;
        mdl_load(tw);
        if (wmode == 2 || (wmode == 1 && !full_before)) begin
            mdl_buf = wval;
            mdl_full = 1'b1;
        end
        for (int k = 0; k < nw; k++) begin
            txq.push_back(tw);
            for (int j = 0; j < 8; j++) begin
                rm[7-j] = bits[8*k+j];
                rl[j]   = bits[8*k+j];
            end
            mdl_rx(rm, rl);
            if (!cfg_cpha || nbits > 8*(k+1)) mdl_load(tw);
        end

        @(negedge clk);
        ssn = 1'b0;
        if (!cfg_cpha) mosi = bits[0];
        if (wmode == 1) begin
            repeat (2) @(negedge clk);
            tx_data = wval;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        repeat (H) @(negedge clk);
        if (wmode == 2) begin
            tx_data = wval;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("busy_in_frame", 32'(busy_m), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            sck = ~cfg_cpol;
            if (cfg_cpha) mosi = bits[i];
            repeat (H) @(negedge clk);
            sck = cfg_cpol;
            if (!cfg_cpha) mosi = bits[i+1];
            repeat (H) @(negedge clk);
        end
        ssn = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic frame_checks();
        chk("busy_m", 32'(busy_m), 32'd0);
        chk("busy_l", 32'(busy_l), 32'd0);
        chk("tx_underrun_m", 32'(tx_underrun_m), 32'(mdl_unr));
        chk("tx_underrun_l", 32'(tx_underrun_l), 32'(mdl_unr));
        chk("rx_overrun_m", 32'(rx_overrun_m), 32'(mdl_ovr));
        chk("tx_ready_m", 32'(tx_ready_m), 32'(!mdl_full));
        chk("tx_ready_l", 32'(tx_ready_l), 32'(!mdl_full));
        chk("miso_idle", 32'(miso_m), 32'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rxq_m.size() != 0 || rxq_l.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rx_queue_drained", 32'(rxq_m.size() + rxq_l.size()), 32'd0);
        chk("tx_queue_drained", 32'(txq.size()), 32'd0);
    endtask

    // miso monitor: assembles bits at the master's sample edges.
    initial begin : tx_mon
        logic prev, lead;
        int cnt;
        logic [7:0] am, al, e;
        prev = 1'b0;
        cnt = 0;
        am = '0;
        al = '0;
        forever begin
            @(sck or ssn);
            if (ssn) begin
                cnt = 0;
            end else if (sck !== prev) begin
                lead = (sck !== cfg_cpol);
                if (lead ^ cfg_cpha) begin
                    am = {am[6:0], miso_m};
                    al = {miso_l, al[7:1]};
                    cnt++;
                    if (cnt == 8) begin
                        cnt = 0;
                        if (txq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL miso_word unexpected actual=%0h required=none", am);
                        end else begin
                            e = txq.pop_front();
                            chk("miso_word_m", 32'(am), 32'(e));
                            chk("miso_word_l", 32'(al), 32'(e));
                        end
                    end
                end
            end
            prev = sck;
        end
    end

    // rx monitor: every accepted rx word must be the next predicted one.
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && rx_ready) begin
                if (rx_valid_m) begin
                    if (rxq_m.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_data_m unexpected actual=%0h required=none", rx_data_m);
                    end else chk("rx_data_m", 32'(rx_data_m), 32'(rxq_m.pop_front()));
                end
                if (rx_valid_l) begin
                    if (rxq_l.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_data_l unexpected actual=%0h required=none", rx_data_l);
                    end else chk("rx_data_l", 32'(rx_data_l), 32'(rxq_l.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_miso"}, 32'(miso_m | miso_l), 32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready_m & tx_ready_l), 32'd1);
        chk({tag, "_tx_underrun"}, 32'(tx_underrun_m | tx_underrun_l), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data_m | rx_data_l), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid_m | rx_valid_l), 32'd0);
        chk({tag, "_rx_overrun"}, 32'(rx_overrun_m | rx_overrun_l), 32'd0);
        chk({tag, "_busy"}, 32'(busy_m | busy_l), 32'd0);
    endtask

    initial begin : stim
        int nb, wm;
        logic [63:0] rb;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, 0xA5 out, 0x3C in.
        set_mode(1'b0, 1'b0);
        write_tx(8'hA5);
        run_frame(8, msbw(8'h3C, 8'h00, 8'h00), 0, 8'h00);
        drain();
        frame_checks();

        // Modes 1, 2, 3 with 0x81 out, 0x7E in.
        for (int m = 1; m < 4; m++) begin
            clear_flags();
            set_mode(1'(m >> 1), 1'(m & 1));
            write_tx(8'h81);
            run_frame(8, msbw(8'h7E, 8'h00, 8'h00), 0, 8'h00);
            drain();
            frame_checks();
        end

        // Two words in one frame, second written after the first load.
        clear_flags();
        set_mode(1'b0, 1'b1);
        write_tx(8'h11);
        run_frame(16, msbw(8'h96, 8'h3A, 8'h00), 2, 8'h22);
        drain();
        frame_checks();

        // Empty buffer frame.
        set_mode(1'b0, 1'b0);
        clear_flags();
        run_frame(8, msbw(8'hF0, 8'h00, 8'h00), 0, 8'h00);
        drain();
        frame_checks();
        clear_flags();

        // Write landing in the same clk as the frame-start load.
        set_mode(1'b0, 1'b1);
        run_frame(8, msbw(8'h5D, 8'h00, 8'h00), 1, 8'h6B);
        drain();
        frame_checks();
        run_frame(8, msbw(8'h24, 8'h00, 8'h00), 0, 8'h00);
        drain();
        frame_checks();

        // Two words with the consumer stalled.
        clear_flags();
        set_mode(1'b0, 1'b0);
        @(negedge clk);
        rx_ready = 1'b0;
        hold = 1'b1;
        run_frame(16, msbw(8'h5C, 8'hC3, 8'h00), 0, 8'h00);
        chk("hold_rx_data_m", 32'(rx_data_m), 32'(mdl_last_m));
        chk("hold_rx_data_l", 32'(rx_data_l), 32'(mdl_last_l));
        chk("hold_rx_valid", 32'(rx_valid_m), 32'd1);
        frame_checks();
        @(negedge clk);
        rx_ready = 1'b1;
        hold = 1'b0;
        mdl_pend = 1'b0;
        drain();

        // Aborted after 5 bits, then a realigned full frame.
        write_tx(8'h3E);
        run_frame(5, msbw(8'hFF, 8'h00, 8'h00), 0, 8'h00);
        drain();
        frame_checks();
        run_frame(8, msbw(8'h4B, 8'h00, 8'h00), 0, 8'h00);
        drain();
        frame_checks();

        // Reset in the middle of a word.
        write_tx(8'h5A);
        @(negedge clk);
        ssn = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1;
            mosi = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
            repeat (H) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        mdl_full = 1'b0;
        mdl_unr = 1'b0;
        mdl_ovr = 1'b0;
        mdl_pend = 1'b0;
        @(negedge clk);
        ssn = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2*H) @(negedge clk);
        write_tx(8'hC7);
        run_frame(8, msbw(8'h19, 8'h00, 8'h00), 0, 8'h00);
        drain();
        frame_checks();

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) clear_flags();
            if (!mdl_full && $urandom_range(0, 1) == 1) write_tx(8'($urandom));
            nb = ($urandom_range(0, 3) != 0) ? 8 * $urandom_range(1, 3) : $urandom_range(1, 23);
            wm = $urandom_range(0, 2);
            rb = {32'($urandom), 32'($urandom)};
            run_frame(nb, rb, wm, 8'($urandom));
            drain();
            frame_checks();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
